xalu_md: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Drives XALUOut_E, which holds HI or LO for mfhi/mflo, into the E/M pipeline register.
- Exposes busy and stall_req; the hazard unit uses stall_req to freeze F/D and clear D/E while a multiply/divide is pending.

---
 rtl/xalu_defs.sv | 22 ++
 rtl/xalu_md_if.sv | 30 +++
 rtl/xalu_md.sv | 136 +++++++++++++
 tb/tb_xalu_md.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_defs.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and a small op-class helper.
package xalu_defs;

  localparam logic [2:0] XALU_OP_NOP   = 3'd0;
  localparam logic [2:0] XALU_OP_MULT  = 3'd1;
  localparam logic [2:0] XALU_OP_MULTU = 3'd2;
  localparam logic [2:0] XALU_OP_DIV   = 3'd3;
  localparam logic [2:0] XALU_OP_DIVU  = 3'd4;
  localparam logic [2:0] XALU_OP_MTHI  = 3'd5;
  localparam logic [2:0] XALU_OP_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == XALU_OP_MULT) || (op == XALU_OP_MULTU) ||
           (op == XALU_OP_DIV)  || (op == XALU_OP_DIVU);
  endfunction

endpackage

// File: rtl/xalu_md_if.sv
// Bus between the E-stage controller/forwarding network and xalu_md.
//
// Handshake: start is a one-cycle request qualified by the controller; it is
// accepted only at a clock edge where busy=0. A multi-cycle op raises busy at
// its start edge and drops it at the edge that writes HI/LO. stall_req tells
// the hazard unit to hold F/D while an op is being issued or is in flight;
// starts presented while busy=1 are dropped by the unit.
interface xalu_md_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        start;
  logic        hilo_sel;
  logic [31:0] XALUOut;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        state_dbg;

  modport master (
    output A, B, op, start, hilo_sel,
    input  XALUOut, busy, stall_req, HI, LO, state_dbg
  );

  modport slave (
    input  A, B, op, start, hilo_sel,
    output XALUOut, busy, stall_req, HI, LO, state_dbg
  );
endinterface

// File: rtl/xalu_md.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed in
// the issue cycle and parked in pend_hi/pend_lo; a down-counter models the
// latency and commits the parked result when it expires.
module xalu_md
  import xalu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic      clk,
  input logic      reset,
  xalu_md_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;

  logic          busy;
  logic          is_div;
  logic          is_signed;
  logic [63:0]   mul_a, mul_b, mul_p;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, uq, ur, quo, rem;
  logic [63:0]   md_res;

  // Combinational 64-bit result {HI, LO} for the op currently presented.
  always_comb begin
    is_div    = (bus.op == XALU_OP_DIV) || (bus.op == XALU_OP_DIVU);
    is_signed = (bus.op == XALU_OP_MULT) || (bus.op == XALU_OP_DIV);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact.
    mul_a = is_signed ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
    mul_b = is_signed ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
    mul_p = mul_a * mul_b;

    // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000, so
    // the overflow case (-2^31 / -1) wraps to LO=0x80000000, HI=0 naturally.
    a_neg = is_signed & bus.A[31];
    b_neg = is_signed & bus.B[31];
    a_mag = a_neg ? (~bus.A + 32'd1) : bus.A;
    b_mag = b_neg ? (~bus.B + 32'd1) : bus.B;
    uq    = 32'hFFFF_FFFF;
    ur    = 32'd0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem = a_neg ? (~ur + 32'd1) : ur;

    if (is_div) begin
      md_res = (bus.B == 32'd0) ? {bus.A, 32'hFFFF_FFFF} : {rem, quo};
    end else begin
      md_res = mul_p;
    end
  end

  // Next-state logic: issue from IDLE, count down and commit in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            XALU_OP_MULT, XALU_OP_MULTU: begin
              pend_hi_d = md_res[63:32];
              pend_lo_d = md_res[31:0];
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = S_RUN;
            end
            XALU_OP_DIV, XALU_OP_DIVU: begin
              pend_hi_d = md_res[63:32];
              pend_lo_d = md_res[31:0];
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            XALU_OP_MTHI: hi_d = bus.A;
            XALU_OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign bus.busy      = busy;
  assign bus.stall_req = (bus.start && is_md_op(bus.op)) || busy;
  assign bus.XALUOut   = bus.hilo_sel ? hi_q : lo_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_xalu_md.sv
// Self-checking bench for xalu_md: directed table, randomized ops against a
// plain-arithmetic reference model, and hand-written corner sequences.
module tb_xalu_md;
  import xalu_defs::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic clk = 1'b0;
  logic reset;
  xalu_md_if bus ();

  xalu_md dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: {HI, LO} after the op, from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] res;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    res = cur;
    case (o)
      XALU_OP_MULT:  res = sa * sb;
      XALU_OP_MULTU: res = {32'd0, a} * {32'd0, b};
      XALU_OP_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      XALU_OP_DIVU: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      XALU_OP_MTHI: res = {a, cur[31:0]};
      XALU_OP_MTLO: res = {cur[63:32], a};
      default: ;
    endcase
    return res;
  endfunction

  function automatic int lat_of(input logic [2:0] o);
    if (o == XALU_OP_MULT || o == XALU_OP_MULTU) return N_MULT;
    if (o == XALU_OP_DIV || o == XALU_OP_DIVU) return N_DIV;
    return 0;
  endfunction

  // Issue one op, measure busy length, check HI/LO and both XALUOut selects.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int cyc;
    @(negedge clk);
    bus.op = o; bus.A = a; bus.B = b; bus.start = 1'b1;
    #1 chk({nm, " stall_req"}, 64'(bus.stall_req), 64'(lat_of(o) != 0));
    @(posedge clk);
    #1 bus.start = 1'b0; bus.op = XALU_OP_NOP;
    cyc = 0;
    while (bus.busy && cyc < 64) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    chk({nm, " busy_cycles"}, 64'(cyc), 64'(lat_of(o)));
    chk({nm, " HI"}, 64'(bus.HI), 64'(ehi));
    chk({nm, " LO"}, 64'(bus.LO), 64'(elo));
    bus.hilo_sel = 1'b0;
    #1 chk({nm, " XALUOut_lo"}, 64'(bus.XALUOut), 64'(elo));
    bus.hilo_sel = 1'b1;
    #1 chk({nm, " XALUOut_hi"}, 64'(bus.XALUOut), 64'(ehi));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    logic [2:0]  o;
    logic [31:0] a, b;
    int cyc;

    // Reset
    bus.A = '0; bus.B = '0; bus.op = XALU_OP_NOP; bus.start = 1'b0; bus.hilo_sel = 1'b0;
    reset = 1'b1;
    #3;
    chk("reset HI", 64'(bus.HI), 64'd0);
    chk("reset LO", 64'(bus.LO), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset XALUOut", 64'(bus.XALUOut), 64'd0);
    chk("reset stall_req", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    tbl[0] = '{XALU_OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg2x3"};
    tbl[1] = '{XALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    tbl[2] = '{XALU_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
    tbl[3] = '{XALU_OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, "divu_by0"};
    tbl[4] = '{XALU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"};
    tbl[5] = '{XALU_OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0"};
    tbl[6] = '{XALU_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7byneg2"};
    tbl[7] = '{XALU_OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, "divu_big"};
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].nm);
    end
    m_hi = tbl[7].hi;
    m_lo = tbl[7].lo;

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(1, 6));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp_q.push_back(ref_op(o, a, b, {m_hi, m_lo}));
      e = exp_q.pop_front();
      run_op(o, a, b, e[63:32], e[31:0], "rand");
      m_hi = e[63:32];
      m_lo = e[31:0];
    end

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    bus.op = XALU_OP_MTHI; bus.A = 32'h1234_5678; bus.start = 1'b1;
    #1 chk("mthi stall_req", 64'(bus.stall_req), 64'd0);
    @(posedge clk);
    #1 chk("mthi HI", 64'(bus.HI), 64'h1234_5678);
    chk("mthi busy", 64'(bus.busy), 64'd0);
    bus.op = XALU_OP_MTLO; bus.A = 32'h9ABC_DEF0;
    #1 chk("mtlo stall_req", 64'(bus.stall_req), 64'd0);
    @(posedge clk);
    #1 chk("mtlo LO", 64'(bus.LO), 64'h9ABC_DEF0);
    chk("mtlo HI kept", 64'(bus.HI), 64'h1234_5678);
    chk("mtlo busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.op = XALU_OP_NOP;

    // Asynchronous reset in cycle 4 of a DIV
    @(negedge clk);
    bus.op = XALU_OP_DIV; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.op = XALU_OP_NOP;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid busy", 64'(bus.busy), 64'd0);
    chk("rst_mid HI", 64'(bus.HI), 64'd0);
    chk("rst_mid LO", 64'(bus.LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("rst_after busy", 64'(bus.busy), 64'd0);
    chk("rst_after HI", 64'(bus.HI), 64'd0);
    chk("rst_after LO", 64'(bus.LO), 64'd0);

    // Starts presented while busy are ignored
    @(negedge clk);
    bus.op = XALU_OP_MULT; bus.A = 32'd3; bus.B = 32'd4; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.op = XALU_OP_NOP;
    cyc = 0;
    while (bus.busy && cyc < 64) begin
      cyc++;
      bus.start = 1'b0; bus.op = XALU_OP_NOP;
      if (cyc == 2) begin
        bus.op = XALU_OP_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
      end else if (cyc == 3) begin
        bus.op = XALU_OP_MTHI; bus.A = 32'hDEAD_BEEF; bus.start = 1'b1;
      end else if (cyc == 4) begin
        #1 chk("busy stall_req", 64'(bus.stall_req), 64'd1);
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0; bus.op = XALU_OP_NOP;
    chk("busy_start cycles", 64'(cyc), 64'(N_MULT));
    chk("busy_start HI", 64'(bus.HI), 64'd0);
    chk("busy_start LO", 64'(bus.LO), 64'd12);
    repeat (12) @(posedge clk);
    #1 chk("busy_start late busy", 64'(bus.busy), 64'd0);
    chk("busy_start late HI", 64'(bus.HI), 64'd0);
    chk("busy_start late LO", 64'(bus.LO), 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
